// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory store and its byte packer.
package imem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StDone = 2'd2
  } state_e;

  // MIPS sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  function automatic int unsigned bytes_per_word(int unsigned mem_width);
    return mem_width / 8;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a big-endian byte stream into words; word_valid_o pulses with the last byte of each word.
module byte_word_packer
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 word_valid_o,
  output logic [MEM_WIDTH-1:0] word_o
);

  localparam int unsigned Bytes = bytes_per_word(MEM_WIDTH);
  localparam int unsigned CntW  = $clog2(Bytes) + 1;

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [MEM_WIDTH-9:0] pack_q, pack_d;
  logic                 last_byte;

  assign last_byte    = (cnt_q == CntW'(Bytes - 1));
  assign word_o       = {pack_q, byte_i};
  assign word_valid_o = byte_valid_i && last_byte;

  always_comb begin
    cnt_d  = cnt_q;
    pack_d = pack_q;
    if (clear_i) begin
      cnt_d  = '0;
      pack_d = '0;
    end else if (byte_valid_i) begin
      if (last_byte) begin
        cnt_d  = '0;
        pack_d = '0;
      end else begin
        cnt_d  = cnt_q + CntW'(1);
        // Earlier bytes migrate upward so the first byte ends in the top lane.
        pack_d = word_o[MEM_WIDTH-9:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pack_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/instruction_memory_store.sv
// Instruction memory with a zero-latency fetch port and a byte-stream program loader.
module instruction_memory_store
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WIDTH = 32,
  parameter int unsigned MEM_SIZE  = 256,
  localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        mem_addr,
  input  logic                 mem_read_en,
  output logic [MEM_WIDTH-1:0] mem_read_val,
  input  logic                 load_start,
  input  logic [AW:0]          load_len,
  input  logic                 load_byte_valid,
  input  logic [7:0]           load_byte,
  output logic                 load_byte_ready,
  output logic                 load_busy,
  output logic                 load_done,
  output logic [AW:0]          load_words
);

  state_e               state_q, state_d;
  logic [AW-1:0]        word_addr_q, word_addr_d;
  logic [AW:0]          load_words_q, load_words_d;
  logic [AW:0]          len_q, len_d;
  logic [AW:0]          len_clamped;
  logic                 start_ok;
  logic                 byte_accept;
  logic                 word_valid;
  logic                 last_word;
  logic [MEM_WIDTH-1:0] word;
  logic [MEM_WIDTH-1:0] mem_q [MEM_SIZE];

  assign len_clamped = (load_len > (AW+1)'(MEM_SIZE)) ? (AW+1)'(MEM_SIZE) : load_len;
  assign start_ok    = load_start && (state_q != StLoad);
  assign byte_accept = load_byte_valid && (state_q == StLoad);
  assign last_word   = word_valid && ((load_words_q + (AW+1)'(1)) == len_q);

  byte_word_packer #(
    .MEM_WIDTH(MEM_WIDTH)
  ) u_packer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (start_ok),
    .byte_valid_i(byte_accept),
    .byte_i      (load_byte),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (load_start) begin
          state_d = (len_clamped == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        if (last_word) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load_byte_ready = (state_q == StLoad);
    load_busy       = (state_q == StLoad);
    load_done       = (state_q == StDone);
    load_words      = load_words_q;
  end

  always_comb begin
    word_addr_d  = word_addr_q;
    load_words_d = load_words_q;
    len_d        = len_q;
    if (start_ok) begin
      word_addr_d  = '0;
      load_words_d = '0;
      len_d        = len_clamped;
    end else if (word_valid) begin
      load_words_d = load_words_q + (AW+1)'(1);
      // Hold the address on the final word so it never wraps past MEM_SIZE-1.
      if (!last_word) begin
        word_addr_d = word_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr_q  <= '0;
      load_words_q <= '0;
      len_q        <= '0;
    end else begin
      word_addr_q  <= word_addr_d;
      load_words_q <= load_words_d;
      len_q        <= len_d;
    end
  end

  // Storage is deliberately not reset so a reset mid-load keeps already written words.
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem_q[word_addr_q] <= word;
    end
  end

  always_comb begin
    mem_read_val = MEM_WIDTH'(NOP_WORD);
    if (mem_read_en && (state_q != StLoad)) begin
      mem_read_val = mem_q[mem_addr];
    end
  end

endmodule

// File: tb/tb_instruction_memory_store.sv
// Randomized self-checking bench for instruction_memory_store against a word-array model.
module tb_instruction_memory_store;

  localparam int MW = 32;
  localparam int MS = 256;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic          mem_read_en;
  logic [MW-1:0] mem_read_val;
  logic          load_start;
  logic [AW:0]   load_len;
  logic          load_byte_valid;
  logic [7:0]    load_byte;
  logic          load_byte_ready;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   load_words;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [MS];
  bit          known [MS];
  logic [7:0]  byte_q [$];

  always #5 clk = ~clk;

  instruction_memory_store #(
    .MEM_WIDTH(MW),
    .MEM_SIZE (MS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_addr       (mem_addr),
    .mem_read_en    (mem_read_en),
    .mem_read_val   (mem_read_val),
    .load_start     (load_start),
    .load_len       (load_len),
    .load_byte_valid(load_byte_valid),
    .load_byte      (load_byte),
    .load_byte_ready(load_byte_ready),
    .load_busy      (load_busy),
    .load_done      (load_done),
    .load_words     (load_words)
  );

  // Runs one load: feeds `feed` bytes from byte_q (all of them when feed < 0).
  task automatic do_load(input int len, input int feed, input bit gaps, input bit start_byte,
                         input bit mid_start);
    int          exp_len;
    int          total;
    int          idx;
    int          budget;
    bit          v;
    logic [31:0] acc;
    exp_len = (len > MS) ? MS : len;
    total   = exp_len * 4;
    if (feed < 0 || feed > total) feed = total;
    while (byte_q.size() < total) byte_q.push_back(8'($urandom));
    idx = 0;
    v   = 1'b0;
    acc = '0;
    @(negedge clk);
    load_start      = 1'b1;
    load_len        = (AW+1)'(len);
    load_byte_valid = start_byte;
    load_byte       = 8'hA5;
    @(negedge clk);
    load_start      = 1'b0;
    load_byte_valid = 1'b0;
    if (exp_len == 0) begin
      checks++;
      if (load_done !== 1'b1 || load_busy !== 1'b0 || load_words !== '0) begin
        errors++;
        $display("FAIL zero_len: done=%b busy=%b words=%0d, want done=1 busy=0 words=0",
                 load_done, load_busy, load_words);
      end
      byte_q.delete();
      return;
    end
    budget = feed * 2 + 20;
    while (idx < feed && budget > 0) begin
      checks++;
      if (load_byte_ready !== 1'b1 || load_busy !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: ready=%b busy=%b at byte %0d, want 1 1",
                 load_byte_ready, load_busy, idx);
      end
      if ($urandom_range(0, 3) == 0) begin
        mem_read_en = 1'b1;
        mem_addr    = AW'($urandom);
        #1;
        checks++;
        if (mem_read_val !== 32'h0) begin
          errors++;
          $display("FAIL fetch_during_load: got %h, want 00000000", mem_read_val);
        end
        mem_read_en = 1'b0;
      end
      v               = gaps ? ~v : 1'b1;
      load_byte_valid = v;
      load_byte       = v ? byte_q[idx] : 8'($urandom);
      if (mid_start && idx == 4) begin
        load_start = 1'b1;
        load_len   = (AW+1)'(1);
      end
      @(negedge clk);
      load_start = 1'b0;
      if (v) begin
        acc = {acc[23:0], byte_q[idx]};
        idx++;
        if (idx % 4 == 0) begin
          model_mem[idx/4-1] = acc;
          known[idx/4-1]     = 1'b1;
        end
      end
      budget--;
    end
    load_byte_valid = 1'b0;
    if (idx < feed) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: fed %0d of %0d bytes", idx, feed);
    end
    checks++;
    if (feed == total) begin
      if (load_done !== 1'b1 || load_byte_ready !== 1'b0 || load_busy !== 1'b0 ||
          load_words !== (AW+1)'(exp_len)) begin
        errors++;
        $display("FAIL load_end: done=%b ready=%b busy=%b words=%0d, want 1 0 0 %0d",
                 load_done, load_byte_ready, load_busy, load_words, exp_len);
      end
    end else begin
      if (load_busy !== 1'b1 || load_words !== (AW+1)'(idx / 4)) begin
        errors++;
        $display("FAIL load_partial: busy=%b words=%0d, want 1 %0d", load_busy, load_words,
                 idx / 4);
      end
    end
    byte_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_byte_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 ||
        load_words !== '0 || mem_read_val !== 32'h0) begin
      errors++;
      $display("FAIL reset: ready=%b busy=%b done=%b words=%0d rd=%h, want all zero",
               load_byte_ready, load_busy, load_done, load_words, mem_read_val);
    end
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    mem_read_en = 1'b1;
    mem_addr    = AW'(5);
    @(negedge clk);
    mem_read_en = 1'b0;
    checks++;
    if (load_busy !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b done=%b, want 0 0", load_busy, load_done);
    end
  endtask

  task automatic test_basic_load();
    byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    do_load(2, -1, 1'b0, 1'b1, 1'b0);
    for (int a = 0; a < 2; a++) begin
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== ((a == 0) ? 32'h2008_0005 : 32'h0)) begin
        errors++;
        $display("FAIL basic_read[%0d]: got %h, want %h", a, mem_read_val,
                 (a == 0) ? 32'h2008_0005 : 32'h0);
      end
    end
    mem_read_en = 1'b0;
    mem_addr    = '0;
    #1;
    checks++;
    if (mem_read_val !== 32'h0) begin
      errors++;
      $display("FAIL read_disabled: got %h, want 00000000", mem_read_val);
    end
  endtask

  task automatic test_toggle_valid();
    do_load(1, -1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    mem_read_en = 1'b1;
    mem_addr    = '0;
    #1;
    checks++;
    if (mem_read_val !== model_mem[0]) begin
      errors++;
      $display("FAIL toggle_read: got %h, want %h", mem_read_val, model_mem[0]);
    end
    mem_read_en = 1'b0;
  endtask

  task automatic test_clamp();
    do_load(300, -1, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < MS; a++) begin
      @(negedge clk);
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== model_mem[a]) begin
        errors++;
        $display("FAIL clamp_read[%0d]: got %h, want %h", a, mem_read_val, model_mem[a]);
      end
    end
    mem_read_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] old1;
    old1 = model_mem[1];
    do_load(2, 6, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (load_byte_ready !== 1'b0 || load_busy !== 1'b0 || load_done !== 1'b0 ||
        load_words !== '0) begin
      errors++;
      $display("FAIL mid_reset: ready=%b busy=%b done=%b words=%0d, want all zero",
               load_byte_ready, load_busy, load_done, load_words);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 2; a++) begin
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== ((a == 0) ? model_mem[0] : old1)) begin
        errors++;
        $display("FAIL mid_reset_keep[%0d]: got %h, want %h", a, mem_read_val,
                 (a == 0) ? model_mem[0] : old1);
      end
    end
    mem_read_en = 1'b0;
    do_load(1, -1, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 2; a++) begin
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== model_mem[a]) begin
        errors++;
        $display("FAIL restart_read[%0d]: got %h, want %h", a, mem_read_val, model_mem[a]);
      end
    end
    mem_read_en = 1'b0;
  endtask

  task automatic test_zero_len_and_ignored_start();
    logic [31:0] old0;
    old0 = model_mem[0];
    do_load(0, -1, 1'b0, 1'b0, 1'b0);
    mem_read_en = 1'b1;
    mem_addr    = '0;
    #1;
    checks++;
    if (mem_read_val !== old0) begin
      errors++;
      $display("FAIL zero_len_nowrite: got %h, want %h", mem_read_val, old0);
    end
    mem_read_en = 1'b0;
    do_load(2, -1, 1'b1, 1'b0, 1'b1);
    for (int a = 0; a < 2; a++) begin
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== model_mem[a]) begin
        errors++;
        $display("FAIL ignored_start_read[%0d]: got %h, want %h", a, mem_read_val,
                 model_mem[a]);
      end
    end
    mem_read_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++) begin
      do_load(int'($urandom_range(1, 8)), -1, 1'($urandom), 1'($urandom), 1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      mem_read_en = 1'b1;
      mem_addr    = AW'(a);
      #1;
      checks++;
      if (mem_read_val !== model_mem[a]) begin
        errors++;
        $display("FAIL b2b_read[%0d]: got %h, want %h", a, mem_read_val, model_mem[a]);
      end
    end
    mem_read_en = 1'b0;
  endtask

  initial begin
    mem_addr        = '0;
    mem_read_en     = 1'b0;
    load_start      = 1'b0;
    load_len        = '0;
    load_byte_valid = 1'b0;
    load_byte       = '0;
    for (int a = 0; a < MS; a++) begin
      model_mem[a] = 'x;
      known[a]     = 1'b0;
    end
    test_reset();
    test_basic_load();
    test_toggle_valid();
    test_clamp();
    test_reset_mid_load();
    test_zero_len_and_ignored_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
